// File: rtl/unlock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unlock_pkg
// Description : Shared state encoding and width helpers for the parametrised
//               serial unlock controller.
// Revision    : 1.0 - initial release
// ============================================================================
package unlock_pkg;

  // Controller states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    COLLECT  = 3'd0,
    CHECK    = 3'd1,
    UNLOCKED = 3'd2,
    PROGRAM  = 3'd3,
    LOCKOUT  = 3'd4
  } state_e;

  // Bits needed to hold 0..n-1, never less than one bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/unlock_lockout_timer.sv
`default_nettype none
// ============================================================================
// Module      : unlock_lockout_timer
// Description : Load/decrement counter timing the lockout window. done is high
//               whenever the count has reached zero.
// Revision    : 1.0 - initial release
// ============================================================================
module unlock_lockout_timer
  import unlock_pkg::*;
#(
  parameter int LOCKOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int LOCK_W = clog2_min1(LOCKOUT_CYC);
  localparam logic [LOCK_W-1:0] c_load_val = LOCK_W'(LOCKOUT_CYC - 1);

  logic [LOCK_W-1:0] r_cnt;

  // Load the full window on entry, then count down to zero and hold there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= c_load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/param_unlock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : param_unlock_ctrl
// Description : Serial password unlock controller with configurable symbol
//               width and length, failed-attempt counting, timed lockout and
//               in-field password reprogramming while unlocked.
// Revision    : 1.0 - initial release
// ============================================================================
module param_unlock_ctrl
  import unlock_pkg::*;
#(
  parameter int SYM_W       = 4,
  parameter int PWD_LEN     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCKOUT_CYC = 16,
  parameter logic [SYM_W*PWD_LEN-1:0] RESET_PWD = 16'h1234
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [SYM_W-1:0]               sym_data,
  input  logic                           sym_valid,
  output logic                           sym_ready,
  input  logic                           prog_en,
  input  logic                           relock,
  output logic                           unlock,
  output logic                           pwd_incorrect,
  output logic                           locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

  localparam int IDX_W  = clog2_min1(PWD_LEN);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam logic [IDX_W-1:0]  c_last_idx = IDX_W'(PWD_LEN - 1);
  localparam logic [FAIL_W-1:0] c_max_fail = FAIL_W'(MAX_TRIES);

  state_e                        r_state;
  state_e                        w_next;
  logic [IDX_W-1:0]              r_idx;
  logic                          r_mis;
  logic [FAIL_W-1:0]             r_fail;
  logic [FAIL_W-1:0]             w_fail_inc;
  logic [PWD_LEN-1:0][SYM_W-1:0] r_pwd;
  logic [PWD_LEN-1:0][SYM_W-1:0] r_shadow;
  logic [PWD_LEN-1:0][SYM_W-1:0] w_shadow_next;
  logic                          w_accept;
  logic                          w_last;
  logic                          w_sym_diff;
  logic                          w_timer_load;
  logic                          w_timer_dec;
  logic                          w_timer_done;

  // Per-symbol helpers: compare against stored symbol, shadow with new symbol
  always_comb begin
    w_shadow_next        = r_shadow;
    w_shadow_next[r_idx] = sym_data;
    w_sym_diff           = (sym_data != r_pwd[r_idx]);
    w_last               = (r_idx == c_last_idx);
    w_fail_inc           = (r_fail == c_max_fail) ? r_fail : r_fail + 1'b1;
  end

  assign w_accept     = sym_valid && sym_ready;
  assign w_timer_load = (r_state == CHECK) && r_mis && (w_fail_inc == c_max_fail);
  assign w_timer_dec  = (r_state == LOCKOUT);
  assign fail_cnt     = r_fail;

  unlock_lockout_timer #(
    .LOCKOUT_CYC (LOCKOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_timer_load),
    .dec   (w_timer_dec),
    .done  (w_timer_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs; relock always masks sym_ready so a
  // coincident symbol is dropped rather than half-processed
  always_comb begin
    w_next        = r_state;
    sym_ready     = 1'b0;
    unlock        = 1'b0;
    pwd_incorrect = 1'b0;
    locked_out    = 1'b0;
    case (r_state)
      COLLECT: begin
        sym_ready = 1'b1;
        if (sym_valid && w_last) w_next = CHECK;
      end
      CHECK: begin
        pwd_incorrect = r_mis;
        if (r_mis) w_next = (w_fail_inc == c_max_fail) ? LOCKOUT : COLLECT;
        else       w_next = UNLOCKED;
      end
      UNLOCKED: begin
        unlock    = 1'b1;
        sym_ready = prog_en && !relock;
        if (relock)                      w_next = COLLECT;
        else if (prog_en && sym_valid)   w_next = w_last ? UNLOCKED : PROGRAM;
      end
      PROGRAM: begin
        unlock    = 1'b1;
        sym_ready = !relock;
        if (relock)                  w_next = COLLECT;
        else if (sym_valid && w_last) w_next = UNLOCKED;
      end
      LOCKOUT: begin
        locked_out = 1'b1;
        if (w_timer_done) w_next = COLLECT;
      end
      default: w_next = COLLECT;
    endcase
  end

  // Datapath: symbol index, sticky mismatch, failure count and password store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_mis    <= 1'b0;
      r_fail   <= '0;
      r_pwd    <= RESET_PWD;
      r_shadow <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_mis <= r_mis | w_sym_diff;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
          end
        end
        CHECK: begin
          r_idx  <= '0;
          r_mis  <= 1'b0;
          r_fail <= r_mis ? w_fail_inc : '0;
        end
        UNLOCKED, PROGRAM: begin
          if (relock) begin
            r_idx <= '0;
          end else if (w_accept) begin
            r_shadow <= w_shadow_next;
            if (w_last) begin
              r_pwd <= w_shadow_next;
              r_idx <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        LOCKOUT: begin
          if (w_timer_done) r_fail <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_unlock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_unlock_ctrl
// Description : Scoreboard bench for param_unlock_ctrl. Stimulus queues the
//               expected output events; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_unlock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sym_data = 4'h0;
  logic       sym_valid = 1'b0;
  logic       prog_en = 1'b0;
  logic       relock = 1'b0;
  logic       sym_ready;
  logic       unlock;
  logic       pwd_incorrect;
  logic       locked_out;
  logic [1:0] fail_cnt;

  param_unlock_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sym_data      (sym_data),
    .sym_valid     (sym_valid),
    .sym_ready     (sym_ready),
    .prog_en       (prog_en),
    .relock        (relock),
    .unlock        (unlock),
    .pwd_incorrect (pwd_incorrect),
    .locked_out    (locked_out),
    .fail_cnt      (fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_INC, EV_UNL_R, EV_UNL_F, EV_LO_R, EV_LO_F} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
    int  fail;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [15:0] mdl_pwd = 16'h1234;
  int         mdl_fail = 0;
  bit         mdl_unl = 1'b0;
  logic       p_unl = 1'b0;
  logic       p_lo = 1'b0;

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input ev_e k, input int c, input int f);
    exp_t e;
    e.kind = k; e.cyc = c; e.fail = f;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_e k);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d", int'(k), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.fail != int'(fail_cnt)) begin
        n_bad++;
        $display("FAIL event: got kind %0d cyc %0d fail %0d, expected kind %0d cyc %0d fail %0d",
                 int'(k), cyc, fail_cnt, int'(e.kind), e.cyc, e.fail);
      end
    end
  endtask

  // Monitor: detect output events on the falling edge and check them
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_unl = 1'b0;
        p_lo  = 1'b0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL missing_event: kind %0d due cycle %0d, now %0d",
                   int'(exp_q[0].kind), exp_q[0].cyc, cyc);
          void'(exp_q.pop_front());
        end
        if (pwd_incorrect)          observe(EV_INC);
        if (unlock && !p_unl)       observe(EV_UNL_R);
        if (!unlock && p_unl)       observe(EV_UNL_F);
        if (locked_out && !p_lo)    observe(EV_LO_R);
        if (!locked_out && p_lo)    observe(EV_LO_F);
        p_unl = unlock;
        p_lo  = locked_out;
      end
    end
  end

  // Offer one symbol until accepted; h = edge number of the handshake
  task automatic send_sym(input logic [3:0] s, output int h);
    int tries;
    tries = 0;
    h = 0;
    forever begin
      @(negedge clk);
      sym_valid = 1'b1;
      sym_data  = s;
      #1;
      if (sym_ready) begin
        h = cyc + 1;
        break;
      end
      tries++;
      if (tries > 40) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
  endtask

  // Enter a full password attempt and queue the modelled outcome
  task automatic send_pwd(input logic [15:0] p);
    int h;
    h = 0;
    for (int k = 0; k < 4; k++) send_sym(p[k*4 +: 4], h);
    if (p == mdl_pwd) begin
      push(EV_UNL_R, h + 1, 0);
      mdl_fail = 0;
      mdl_unl  = 1'b1;
    end else begin
      push(EV_INC, h, mdl_fail);
      mdl_fail = (mdl_fail < 3) ? mdl_fail + 1 : 3;
      if (mdl_fail == 3) begin
        push(EV_LO_R, h + 1, 3);
        push(EV_LO_F, h + 17, 0);
        mdl_fail = 0;
      end
    end
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  // Program n symbols of p; a full set commits as the new password
  task automatic prog_pwd(input logic [15:0] p, input int n);
    int h;
    h = 0;
    prog_en = 1'b1;
    for (int k = 0; k < n; k++) send_sym(p[k*4 +: 4], h);
    @(negedge clk);
    sym_valid = 1'b0;
    prog_en   = 1'b0;
    if (n == 4) mdl_pwd = p;
  endtask

  task automatic do_relock(input bit with_sym);
    @(negedge clk);
    relock = 1'b1;
    if (with_sym) begin
      sym_valid = 1'b1;
      prog_en   = 1'b1;
    end
    #1;
    if (with_sym) chk("ready_low_on_relock", int'(sym_ready), 0);
    if (mdl_unl) push(EV_UNL_F, cyc + 1, mdl_fail);
    mdl_unl = 1'b0;
    @(negedge clk);
    relock    = 1'b0;
    sym_valid = 1'b0;
    prog_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    sym_valid = 1'b0;
    prog_en   = 1'b0;
    relock    = 1'b0;
    exp_q.delete();
    mdl_pwd  = 16'h1234;
    mdl_fail = 0;
    mdl_unl  = 1'b0;
    #1;
    chk("rst_unlock", int'(unlock), 0);
    chk("rst_locked_out", int'(locked_out), 0);
    chk("rst_pwd_incorrect", int'(pwd_incorrect), 0);
    chk("rst_fail_cnt", int'(fail_cnt), 0);
    chk("rst_sym_ready", int'(sym_ready), 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Hold sym_valid through the lockout window and measure it
  task automatic hold_lockout();
    int n;
    int bad;
    n = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sym_valid = 1'b1;
      sym_data  = 4'h4;
      #1;
      if (locked_out) begin
        n++;
        if (sym_ready) bad++;
      end else if (n > 0) begin
        break;
      end
    end
    sym_valid = 1'b0;
    chk("lockout_cycles", n, 16);
    chk("ready_in_lockout", bad, 0);
    chk("fail_after_lockout", int'(fail_cnt), 0);
  endtask

  initial begin
    #3 do_reset();

    // default password 4,3,2,1 unlocks
    send_pwd(16'h1234);
    repeat (2) @(negedge clk);
    #1 chk("unlock_after_ok", int'(unlock), 1);
    chk("fail_after_ok", int'(fail_cnt), 0);
    do_relock(1'b0);

    // last symbol wrong, then first symbol wrong twice -> lockout
    send_pwd(16'h0234);
    repeat (2) @(negedge clk);
    #1 chk("fail_cnt_1", int'(fail_cnt), 1);
    chk("unlock_after_bad", int'(unlock), 0);
    send_pwd(16'h1230);
    send_pwd(16'h1230);
    hold_lockout();
    send_pwd(16'h1234);

    // reprogram to A,B,C,D; old fails, new unlocks
    prog_pwd(16'hDCBA, 4);
    do_relock(1'b0);
    send_pwd(16'h1234);
    send_pwd(16'hDCBA);

    // reset while programming reverts the password
    prog_pwd(16'h5678, 2);
    @(posedge clk);
    #2 chk("pre_reset_program", int'(unlock), 1);
    do_reset();
    send_pwd(16'h1234);

    // aborted programming keeps the password; relock beats a symbol
    prog_pwd(16'h5678, 2);
    do_relock(1'b1);
    send_pwd(16'h1234);
    do_relock(1'b0);

    // reset during lockout
    send_pwd(16'h0000);
    send_pwd(16'h0000);
    send_pwd(16'h0000);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 chk("pre_reset_lockout", int'(locked_out), 1);
    do_reset();
    send_pwd(16'h1234);

    repeat (5) @(negedge clk);
    #1 chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
